// File: rtl/packet_to_axis.sv
// packet_to_axis: converts a length-delimited packet beat stream into
// AXI-Stream. The byte length and sideband are captured on the sop beat.
// A remaining-byte counter generates tkeep and tlast, and length is checked
// against eop. The output is a registered two-entry skid buffer that
// sustains one beat per clock.
module packet_to_axis #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] pkt_data,
  input  logic                  pkt_valid,
  output logic                  pkt_ready,
  input  logic                  pkt_sop,
  input  logic                  pkt_eop,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  input  logic [ID_WIDTH-1:0]   pkt_id,
  input  logic [DEST_WIDTH-1:0] pkt_dest,
  input  logic [USER_WIDTH-1:0] pkt_user,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  len_err
);

  localparam logic [LEN_WIDTH-1:0] KEEP_LEN = LEN_WIDTH'(KEEP_WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DROP   = 2'd2
  } state_t;

  // One complete output beat, used for both the output and skid registers.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
    logic [ID_WIDTH-1:0]   id;
    logic [DEST_WIDTH-1:0] dest;
    logic [USER_WIDTH-1:0] user;
  } beat_t;

  // Framing state.
  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [DEST_WIDTH-1:0] dest_q, dest_d;
  logic [USER_WIDTH-1:0] user_q, user_d;
  logic                  lenErr_q, lenErr_d;
  logic                  pktReady_q, pktReady_d;

  // Output buffer state.
  beat_t                 outBeat_q, outBeat_d;
  logic                  outValid_q, outValid_d;
  beat_t                 skidBeat_q, skidBeat_d;
  logic                  skidValid_q, skidValid_d;

  // Intermediate decode of the current input beat.
  logic                  accept;
  logic                  inIdle;
  logic                  dataBeat;
  logic                  isFinal;
  logic                  emit;
  logic [LEN_WIDTH-1:0]  remCur;
  logic [KEEP_WIDTH-1:0] finalKeep;
  logic [USER_WIDTH-1:0] sideUser;
  beat_t                 newBeat;
  logic                  popOut;

  // Frame the input beat: decide whether it becomes an output beat, how tkeep
  // and tlast are formed, where the FSM goes and whether a length error fires.
  always_comb begin
    accept   = pkt_valid && pktReady_q;
    inIdle   = (state_q == IDLE);
    remCur   = inIdle ? pkt_len : rem_q;
    sideUser = inIdle ? pkt_user : user_q;
    isFinal  = (remCur <= KEEP_LEN);

    for (int i = 0; i < KEEP_WIDTH; i++) begin
      finalKeep[i] = (LEN_WIDTH'(i) < remCur);
    end

    state_d  = state_q;
    rem_d    = rem_q;
    id_d     = id_q;
    dest_d   = dest_q;
    user_d   = user_q;
    lenErr_d = 1'b0;
    dataBeat = 1'b0;
    emit     = 1'b0;

    newBeat.data = pkt_data;
    newBeat.keep = '1;
    newBeat.last = 1'b0;
    newBeat.id   = inIdle ? pkt_id : id_q;
    newBeat.dest = inIdle ? pkt_dest : dest_q;
    newBeat.user = sideUser;

    if (accept) begin
      case (state_q)
        IDLE: begin
          if (!pkt_sop) begin
            lenErr_d = 1'b1;
          end else if (pkt_len == '0) begin
            lenErr_d = 1'b1;
            state_d  = pkt_eop ? IDLE : DROP;
          end else begin
            id_d     = pkt_id;
            dest_d   = pkt_dest;
            user_d   = pkt_user;
            dataBeat = 1'b1;
          end
        end
        ACTIVE: begin
          dataBeat = 1'b1;
        end
        DROP: begin
          if (pkt_eop) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    if (dataBeat) begin
      emit = 1'b1;
      if (isFinal) begin
        newBeat.last = 1'b1;
        newBeat.keep = finalKeep;
        rem_d        = remCur;
        if (pkt_eop) begin
          state_d = IDLE;
        end else begin
          state_d  = DROP;
          lenErr_d = 1'b1;
        end
      end else if (pkt_eop) begin
        newBeat.last    = 1'b1;
        newBeat.user[0] = 1'b1;
        lenErr_d        = 1'b1;
        rem_d           = remCur;
        state_d         = IDLE;
      end else begin
        rem_d   = remCur - KEEP_LEN;
        state_d = ACTIVE;
      end
    end
  end

  // Steer framed beats into the output register or the skid register so
  // the output stays stable under backpressure and nothing is reordered.
  always_comb begin
    popOut      = outValid_q && m_axis_tready;
    outBeat_d   = outBeat_q;
    outValid_d  = outValid_q;
    skidBeat_d  = skidBeat_q;
    skidValid_d = skidValid_q;

    if (popOut || !outValid_q) begin
      if (skidValid_q) begin
        outBeat_d   = skidBeat_q;
        outValid_d  = 1'b1;
        skidValid_d = 1'b0;
        if (emit) begin
          skidBeat_d  = newBeat;
          skidValid_d = 1'b1;
        end
      end else begin
        outValid_d = emit;
        if (emit) begin
          outBeat_d = newBeat;
        end
      end
    end else if (emit) begin
      skidBeat_d  = newBeat;
      skidValid_d = 1'b1;
    end

    // DROP swallows beats without needing output space.
    pktReady_d = (state_d == DROP) || !skidValid_d;
  end

  // Register FSM, counters, sideband, buffers and outputs; reset clears
  // everything including any partially buffered packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      id_q        <= '0;
      dest_q      <= '0;
      user_q      <= '0;
      lenErr_q    <= 1'b0;
      pktReady_q  <= 1'b0;
      outBeat_q   <= '0;
      outValid_q  <= 1'b0;
      skidBeat_q  <= '0;
      skidValid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      id_q        <= id_d;
      dest_q      <= dest_d;
      user_q      <= user_d;
      lenErr_q    <= lenErr_d;
      pktReady_q  <= pktReady_d;
      outBeat_q   <= outBeat_d;
      outValid_q  <= outValid_d;
      skidBeat_q  <= skidBeat_d;
      skidValid_q <= skidValid_d;
    end
  end

  assign pkt_ready     = pktReady_q;
  assign len_err       = lenErr_q;
  assign m_axis_tvalid = outValid_q;
  assign m_axis_tdata  = outBeat_q.data;
  assign m_axis_tkeep  = outBeat_q.keep;
  assign m_axis_tlast  = outBeat_q.last;
  assign m_axis_tid    = outBeat_q.id;
  assign m_axis_tdest  = outBeat_q.dest;
  assign m_axis_tuser  = outBeat_q.user;

endmodule

// File: tb/tb_packet_to_axis.sv
// Testbench for packet_to_axis: directed packets with hand-computed output
// beats pushed into a scoreboard queue, and a monitor that pops and compares
// every output handshake.
module tb_packet_to_axis;

  logic        clk;
  logic        rst_n;
  logic [63:0] pkt_data;
  logic        pkt_valid;
  logic        pkt_ready;
  logic        pkt_sop;
  logic        pkt_eop;
  logic [15:0] pkt_len;
  logic [7:0]  pkt_id;
  logic [7:0]  pkt_dest;
  logic [0:0]  pkt_user;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [7:0]  m_axis_tid;
  logic [7:0]  m_axis_tdest;
  logic [0:0]  m_axis_tuser;
  logic        len_err;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [7:0]  id;
    logic [7:0]  dest;
    logic [0:0]  user;
  } exp_t;

  exp_t expQ[$];
  int   hsLog[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  int   lenErrPulses = 0;
  int   acceptCount = 0;
  logic heldValid = 1'b0;
  exp_t heldBeat;

  packet_to_axis dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pkt_data     (pkt_data),
    .pkt_valid    (pkt_valid),
    .pkt_ready    (pkt_ready),
    .pkt_sop      (pkt_sop),
    .pkt_eop      (pkt_eop),
    .pkt_len      (pkt_len),
    .pkt_id       (pkt_id),
    .pkt_dest     (pkt_dest),
    .pkt_user     (pkt_user),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tid   (m_axis_tid),
    .m_axis_tdest (m_axis_tdest),
    .m_axis_tuser (m_axis_tuser),
    .len_err      (len_err)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to detect bubbles between output handshakes.
  always @(posedge clk) cycle++;

  // Monitor: compare every handshake against the scoreboard, check stability
  // under backpressure, count len_err pulses and check idle output in reset.
  always @(negedge clk) begin
    exp_t act;
    act = '{m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tdest, m_axis_tuser};
    if (!rst_n) begin
      heldValid = 1'b0;
      checks++;
      if (m_axis_tvalid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL resetTvalid: got %b want 0", m_axis_tvalid);
      end
    end else begin
      if (len_err === 1'b1) lenErrPulses++;
      if (heldValid && m_axis_tvalid) begin
        checks++;
        if (act !== heldBeat) begin
          errors++;
          $display("[TB] FAIL stableUnderStall: got %h want %h", act, heldBeat);
        end
      end
      heldValid = m_axis_tvalid && !m_axis_tready;
      heldBeat  = act;
      if (m_axis_tvalid && m_axis_tready) begin
        hsLog.push_back(cycle);
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpectedBeat: got data=%h keep=%h last=%b want no beat",
                   m_axis_tdata, m_axis_tkeep, m_axis_tlast);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          if (act !== e) begin
            errors++;
            $display("[TB] FAIL beat: got data=%h keep=%h last=%b id=%h dest=%h user=%b want data=%h keep=%h last=%b id=%h dest=%h user=%b",
                     act.data, act.keep, act.last, act.id, act.dest, act.user,
                     e.data, e.keep, e.last, e.id, e.dest, e.user);
          end
        end
      end
    end
  end

  function automatic logic [63:0] mkData(input int p, input int b);
    return {32'(p) ^ 32'hA5C3_0000, 32'(b) ^ 32'h0000_5A00};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // Drive one beat and hold it until accepted; called just after a rising edge.
  task automatic applyStimulus(input logic [63:0] data, input logic sop, input logic eop,
                               input logic [15:0] len, input logic [7:0] id,
                               input logic [7:0] dest, input logic [0:0] user);
    bit accepted;
    accepted  = 1'b0;
    pkt_data  = data;
    pkt_sop   = sop;
    pkt_eop   = eop;
    pkt_len   = len;
    pkt_id    = id;
    pkt_dest  = dest;
    pkt_user  = user;
    pkt_valid = 1'b1;
    for (int c = 0; c < 100 && !accepted; c++) begin
      @(negedge clk);
      if (pkt_ready) begin
        @(posedge clk);
        #1;
        accepted = 1'b1;
      end
    end
    pkt_valid = 1'b0;
    if (accepted) acceptCount++;
    else begin
      checks++;
      errors++;
      $display("[TB] FAIL acceptTimeout: got no pkt_ready want accept of %h", data);
    end
  endtask

  task automatic sendPacket(input int p, input int nBeats, input logic [15:0] len,
                            input logic [7:0] id, input logic [7:0] dest, input logic [0:0] user);
    for (int b = 1; b <= nBeats; b++) begin
      applyStimulus(mkData(p, b), b == 1, b == nBeats, len, id, dest, user);
    end
  endtask

  task automatic expectBeat(input int p, input int b, input logic [7:0] keep, input logic last,
                            input logic [7:0] id, input logic [7:0] dest, input logic [0:0] user);
    exp_t e;
    e = '{mkData(p, b), keep, last, id, dest, user};
    expQ.push_back(e);
  endtask

  // Wait (bounded) for the scoreboard to empty plus a few settling cycles.
  task automatic drain();
    for (int c = 0; c < 300 && expQ.size() != 0; c++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("drainEmpty", 64'(expQ.size()), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    pkt_valid = 1'b0; pkt_sop = 1'b0; pkt_eop = 1'b0; pkt_data = '0;
    pkt_len = '0; pkt_id = '0; pkt_dest = '0; pkt_user = '0;
    m_axis_tready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetPktReady", 64'(pkt_ready), 64'd0);
    checkOutput("resetLenErr", 64'(len_err), 64'd0);
    checkOutput("resetTkeep", 64'(m_axis_tkeep), 64'd0);
    checkOutput("resetTdata", m_axis_tdata, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("readyAfterReset", 64'(pkt_ready), 64'd1);

    // len=20, 3 beats: FF, FF, 0F.
    expectBeat(1, 1, 8'hFF, 1'b0, 8'h11, 8'h22, 1'b0);
    expectBeat(1, 2, 8'hFF, 1'b0, 8'h11, 8'h22, 1'b0);
    expectBeat(1, 3, 8'h0F, 1'b1, 8'h11, 8'h22, 1'b0);
    sendPacket(1, 3, 16'd20, 8'h11, 8'h22, 1'b0);
    drain();
    checkOutput("lenErrAfterLen20", 64'(lenErrPulses), 64'd0);

    // Two back-to-back len=16 packets with no idle cycles.
    hsLog.delete();
    expectBeat(2, 1, 8'hFF, 1'b0, 8'h21, 8'h31, 1'b0);
    expectBeat(2, 2, 8'hFF, 1'b1, 8'h21, 8'h31, 1'b0);
    expectBeat(3, 1, 8'hFF, 1'b0, 8'h41, 8'h51, 1'b1);
    expectBeat(3, 2, 8'hFF, 1'b1, 8'h41, 8'h51, 1'b1);
    sendPacket(2, 2, 16'd16, 8'h21, 8'h31, 1'b0);
    sendPacket(3, 2, 16'd16, 8'h41, 8'h51, 1'b1);
    drain();
    checkOutput("backToBackBeats", 64'(hsLog.size()), 64'd4);
    if (hsLog.size() == 4) checkOutput("noBubbles", 64'(hsLog[3] - hsLog[0]), 64'd3);
    checkOutput("lenErrAfterB2B", 64'(lenErrPulses), 64'd0);

    // len=24 ending after 2 beats: short packet, tuser forced, then clean packet.
    expectBeat(4, 1, 8'hFF, 1'b0, 8'h33, 8'h44, 1'b0);
    expectBeat(4, 2, 8'hFF, 1'b1, 8'h33, 8'h44, 1'b1);
    expectBeat(5, 1, 8'h1F, 1'b1, 8'h55, 8'h66, 1'b0);
    sendPacket(4, 2, 16'd24, 8'h33, 8'h44, 1'b0);
    sendPacket(5, 1, 16'd5, 8'h55, 8'h66, 1'b0);
    drain();
    checkOutput("lenErrShort", 64'(lenErrPulses), 64'd1);

    // len=8 with eop on beat 3: one beat out, the rest dropped.
    expectBeat(6, 1, 8'hFF, 1'b1, 8'h61, 8'h62, 1'b0);
    expectBeat(7, 1, 8'h07, 1'b1, 8'h71, 8'h72, 1'b0);
    sendPacket(6, 3, 16'd8, 8'h61, 8'h62, 1'b0);
    sendPacket(7, 1, 16'd3, 8'h71, 8'h72, 1'b0);
    drain();
    checkOutput("lenErrLong", 64'(lenErrPulses), 64'd2);

    // Stray non-sop beat and a zero-length sop+eop beat, then len=1.
    expectBeat(9, 1, 8'h01, 1'b1, 8'h91, 8'h92, 1'b0);
    applyStimulus(mkData(8, 1), 1'b0, 1'b0, 16'd8, 8'h81, 8'h82, 1'b0);
    applyStimulus(mkData(8, 2), 1'b1, 1'b1, 16'd0, 8'h81, 8'h82, 1'b0);
    sendPacket(9, 1, 16'd1, 8'h91, 8'h92, 1'b0);
    drain();
    checkOutput("lenErrFraming", 64'(lenErrPulses), 64'd4);

    // 10-beat packet under 5 cycles of backpressure.
    for (int b = 1; b <= 10; b++) expectBeat(10, b, 8'hFF, b == 10, 8'hA1, 8'hA2, 1'b0);
    acceptCount = 0;
    m_axis_tready = 1'b0;
    fork
      sendPacket(10, 10, 16'd80, 8'hA1, 8'hA2, 1'b0);
      begin
        repeat (5) @(posedge clk);
        #1;
        checkOutput("acceptedUnderStall", 64'(acceptCount), 64'd2);
        checkOutput("readyUnderStall", 64'(pkt_ready), 64'd0);
        m_axis_tready = 1'b1;
      end
    join
    drain();
    checkOutput("lenErrStall", 64'(lenErrPulses), 64'd4);

    // Reset during beat 4 of a 10-beat packet, then a fresh packet.
    expectBeat(11, 1, 8'hFF, 1'b0, 8'hB1, 8'hB2, 1'b0);
    expectBeat(11, 2, 8'hFF, 1'b0, 8'hB1, 8'hB2, 1'b0);
    for (int b = 1; b <= 3; b++) begin
      applyStimulus(mkData(11, b), b == 1, 1'b0, 16'd80, 8'hB1, 8'hB2, 1'b0);
    end
    pkt_data = mkData(11, 4);
    pkt_valid = 1'b1;
    #1;
    rst_n = 1'b0;
    pkt_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("midResetTvalid", 64'(m_axis_tvalid), 64'd0);
    checkOutput("midResetReady", 64'(pkt_ready), 64'd0);
    checkOutput("midResetQueue", 64'(expQ.size()), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    expectBeat(12, 1, 8'hFF, 1'b0, 8'hC1, 8'hC2, 1'b0);
    expectBeat(12, 2, 8'h0F, 1'b1, 8'hC1, 8'hC2, 1'b0);
    sendPacket(12, 2, 16'd12, 8'hC1, 8'hC2, 1'b0);
    drain();
    checkOutput("lenErrFinal", 64'(lenErrPulses), 64'd4);
    checkOutput("finalIdle", 64'(m_axis_tvalid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/packet_to_axis.md
# packet_to_axis

Converts a length-delimited packet beat stream into AXI-Stream, making it the upstream feeder of the team's AXI-Stream-to-packet converter and of the other m_axis consumers in the stream library. The block captures the byte length and sideband at start-of-packet and counts bytes to generate tkeep and tlast. It polices length against end-of-packet and drives a registered skid-buffered output that sustains one beat per clock.

## Interface
- DATA_WIDTH, 64: data width in bits; multiple of 8.
- KEEP_WIDTH, DATA_WIDTH/8: bytes per beat.
- ID_WIDTH, 8: tid width.
- DEST_WIDTH, 8: tdest width.
- USER_WIDTH, 1: tuser width. Bit 0 is the bad-frame flag.
- LEN_WIDTH, 16: packet byte-length field width.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- pkt_data  in  DATA_WIDTH  packet beat; byte 0 is in bits [7:0].
- pkt_valid  in  1  beat valid.
- pkt_ready  out  1  beat accepted when pkt_valid && pkt_ready.
- pkt_sop  in  1  first beat of a packet.
- pkt_eop  in  1  last beat of a packet.
- pkt_len  in  LEN_WIDTH  total packet bytes; sampled on the sop beat only.
- pkt_id, pkt_dest, pkt_user  in  ID/DEST/USER_WIDTH  sideband; sampled on the sop beat only.
- m_axis_tdata  out  DATA_WIDTH  output data.
- m_axis_tkeep  out  KEEP_WIDTH  byte enables.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last beat.
- m_axis_tid, m_axis_tdest, m_axis_tuser  out  ID/DEST/USER_WIDTH  sideband. The sideband is constant for the whole packet.
- len_err  out  1  one-cycle pulse on any framing or length error.

## Operation
- The FSM has three states: IDLE, ACTIVE and DROP.
- **IDLE**
  - An accepted beat without sop is discarded and pulses len_err.
  - An accepted sop beat with pkt_len==0 is discarded, pulses len_err, and moves to DROP. If that beat also has eop, the FSM stays in IDLE.
  - An accepted sop beat with pkt_len>0 latches the length into rem and latches id/dest/user. It is then processed as a data beat (below).
- **Data beat** (in IDLE on sop, or in ACTIVE)
  - final = (rem <= KEEP_WIDTH).
  - Not final: emit tkeep all-ones and tlast=0; rem -= KEEP_WIDTH.
  - Final: emit tlast=1. tkeep has the low rem bits set, or all-ones when rem==KEEP_WIDTH.
    - With eop: go to IDLE.
    - Without eop: go to DROP and pulse len_err.
  - Not final but eop set (short packet): emit tlast=1, tkeep all-ones, and tuser bit 0 forced to 1. Pulse len_err and go to IDLE.
- A sop in ACTIVE is ignored; the beat is treated as data of the current packet.
- **DROP**
  - Accepted beats are discarded with pkt_ready held high, regardless of output space.
  - The eop beat returns the FSM to IDLE.
- rem is LEN_WIDTH bits wide and never underflows; the subtraction occurs only when rem > KEEP_WIDTH.
- **Output buffer**
  - Two-entry skid buffer: one output register plus one skid register.
  - In IDLE and ACTIVE, pkt_ready is registered and is 1 iff the skid register is empty.
  - Beats are never lost, duplicated or reordered.

## Timing
- **Reset values:** m_axis_tvalid=0, pkt_ready=0, len_err=0, all other outputs 0, FSM=IDLE, rem=0.
- pkt_ready rises on the first clock edge after rst_n deasserts.
- **Latency:** a beat accepted on edge N is presented on m_axis at edge N+1 when the output is free.
- **Throughput:** one beat per clock with m_axis_tready held high.
- **Backpressure:** after tready falls, at most one further beat is accepted into the skid register; pkt_ready then drops.
- When tready rises, the output register drains first and the skid beat follows on the next cycle.
- m_axis data and sideband are stable while tvalid=1 and tready=0.
- len_err asserts in the cycle after the offending beat is accepted and lasts exactly one cycle.
- **Reset mid-packet:** all state clears immediately, including any buffered output. No partial packet is emitted after reset.

## Test plan
- DATA_WIDTH=64; sop with len=20 and eop on beat 3 → 3 output beats with tkeep FF, FF, 0F; tlast on beat 3 only; len_err never asserts.
- len=16, 2 beats → tkeep FF, FF with tlast on beat 2. Back-to-back packets separated by zero idle cycles → sustained tvalid with no bubbles.
- len=24, eop on beat 2 → tlast on beat 2, tkeep FF, tuser=1, one len_err pulse; the next packet passes clean.
- len=8, eop on beat 3 → one output beat with tkeep FF and tlast=1; beats 2–3 are absorbed; one len_err pulse; FSM returns to IDLE.
- Stream a 10-beat packet while tready is low for 5 cycles → pkt_ready drops after 2 buffered beats; output data equals input data in order, none lost or duplicated.
- Assert rst_n low during beat 4 of a 10-beat packet, then send a new packet → tvalid is 0 during reset; only the new packet appears, with correct tkeep and tlast.
